// File: rtl/jailbreak_video_pkg.sv
// Default raster timing shared by the H/V generator and the VIDEO block.
// The VIDEO block takes its HP/VP offsets from these same constants.
package jailbreak_video_pkg;
   localparam int H_TOTAL   = 384;
   localparam int H_VISIBLE = 240;
   localparam int HS_START  = 288;
   localparam int HS_WIDTH  = 32;
   localparam int V_TOTAL   = 264;
   localparam int V_VISIBLE = 224;
   localparam int VS_START  = 240;
   localparam int VS_WIDTH  = 8;
   localparam int NMI_LINES = 32;
   localparam int SHIFT_W   = 4;
   localparam int CNT_W     = 9;
endpackage

// File: rtl/jailbreak_sync_window.sv
// In-window flag for a sync pulse whose start point is moved by a signed shift.
// The window never wraps; the elaboration check keeps every legal shift inside [LO, HI).
module jailbreak_sync_window
   import jailbreak_video_pkg::*;
#(
   parameter int START = 0,
   parameter int WIDTH = 1,
   parameter int LO    = 0,
   parameter int HI    = 1 << CNT_W
)(
   input  logic [CNT_W-1:0]   count,
   input  logic [SHIFT_W-1:0] shift,
   output logic               in_win
);
   localparam int SHIFT_MIN = -(1 << (SHIFT_W - 1));
   localparam int SHIFT_MAX = (1 << (SHIFT_W - 1)) - 1;
   localparam logic [CNT_W:0] START_X = START[CNT_W:0];
   localparam logic [CNT_W:0] WIDTH_X = WIDTH[CNT_W:0];

   if ((START + SHIFT_MIN < LO) || (START + SHIFT_MAX + WIDTH > HI)) begin : g_range_check
      $error("sync window %0d+%0d escapes [%0d,%0d) for some shift", START, WIDTH, LO, HI);
   end

   logic [CNT_W:0] cnt_x;
   logic [CNT_W:0] lo;
   logic [CNT_W:0] hi;

   // One extra bit so start+shift+width never aliases back into the raster.
   assign cnt_x  = {1'b0, count};
   assign lo     = START_X + {{(CNT_W + 1 - SHIFT_W){shift[SHIFT_W-1]}}, shift};
   assign hi     = lo + WIDTH_X;
   assign in_win = (cnt_x >= lo) && (cnt_x < hi);
endmodule

// File: rtl/jailbreak_hvgen.sv
// Raster timing generator on VCLKx8: pixel strobes, HP/VP counters, blanks, syncs,
// vblank IRQ and periodic NMI. All flags are registered from next-state counters.
module jailbreak_hvgen
   import jailbreak_video_pkg::*;
#(
   parameter int P_H_TOTAL   = H_TOTAL,
   parameter int P_H_VISIBLE = H_VISIBLE,
   parameter int P_HS_START  = HS_START,
   parameter int P_HS_WIDTH  = HS_WIDTH,
   parameter int P_V_TOTAL   = V_TOTAL,
   parameter int P_V_VISIBLE = V_VISIBLE,
   parameter int P_VS_START  = VS_START,
   parameter int P_VS_WIDTH  = VS_WIDTH,
   parameter int P_NMI_LINES = NMI_LINES
)(
   input  logic               VCLKx8,
   input  logic               RESET_N,
   input  logic [SHIFT_W-1:0] HSHIFT,
   input  logic [SHIFT_W-1:0] VSHIFT,
   input  logic               IRQ_EN,
   input  logic               NMI_EN,
   output logic               VCLK_EN,
   output logic               VCLKx2_EN,
   output logic               VCLKx4_EN,
   output logic [CNT_W-1:0]   HP,
   output logic [CNT_W-1:0]   VP,
   output logic               HBLK,
   output logic               VBLK,
   output logic               HSYNC,
   output logic               VSYNC,
   output logic               VBIRQ,
   output logic               NMIRQ,
   output logic               FRAME
);
   localparam logic [CNT_W-1:0] H_LAST   = 9'(P_H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = 9'(P_V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS_X  = 9'(P_H_VISIBLE);
   localparam logic [CNT_W-1:0] V_VIS_X  = 9'(P_V_VISIBLE);
   localparam logic [CNT_W-1:0] NMI_MASK = 9'(P_NMI_LINES - 1);

   if ((P_NMI_LINES <= 0) || ((P_NMI_LINES & (P_NMI_LINES - 1)) != 0)) begin : g_nmi_check
      $error("NMI period %0d is not a power of two", P_NMI_LINES);
   end

   logic [2:0]         div;
   logic [CNT_W-1:0]   hp_q, vp_q, hp_n, vp_n;
   logic [SHIFT_W-1:0] hs_q, vs_q, hs_n, vs_n;
   logic               hblk_q, vblk_q, hsync_q, vsync_q;
   logic               vbirq_q, nmirq_q, frame_q;
   logic               tick, line_start, frame_start;
   logic               h_win, v_win;

   assign tick = (div == 3'd7);

   always_comb begin
      hp_n        = hp_q;
      vp_n        = vp_q;
      hs_n        = hs_q;
      vs_n        = vs_q;
      line_start  = tick && (hp_q == H_LAST);
      frame_start = line_start && (vp_q == V_LAST);
      if (tick) begin
         if (line_start) begin
            hp_n = '0;
            vp_n = (vp_q == V_LAST) ? '0 : vp_q + 9'd1;
         end else begin
            hp_n = hp_q + 9'd1;
         end
      end
      // Shifts are only ever adopted at the frame boundary, never mid-raster.
      if (frame_start) begin
         hs_n = HSHIFT;
         vs_n = VSHIFT;
      end
   end

   jailbreak_sync_window #(
      .START (P_HS_START),
      .WIDTH (P_HS_WIDTH),
      .LO    (P_H_VISIBLE),
      .HI    (P_H_TOTAL)
   ) u_hwin (
      .count  (hp_n),
      .shift  (hs_n),
      .in_win (h_win)
   );

   jailbreak_sync_window #(
      .START (P_VS_START),
      .WIDTH (P_VS_WIDTH),
      .LO    (P_V_VISIBLE),
      .HI    (P_V_TOTAL)
   ) u_vwin (
      .count  (vp_n),
      .shift  (vs_n),
      .in_win (v_win)
   );

   always_ff @(posedge VCLKx8) begin
      if (!RESET_N) begin
         div     <= '0;
         hp_q    <= '0;
         vp_q    <= '0;
         hs_q    <= '0;
         vs_q    <= '0;
         hblk_q  <= 1'b0;
         vblk_q  <= 1'b0;
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
         vbirq_q <= 1'b0;
         nmirq_q <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         div     <= div + 3'd1;
         vbirq_q <= 1'b0;
         nmirq_q <= 1'b0;
         if (tick) begin
            hp_q    <= hp_n;
            vp_q    <= vp_n;
            hs_q    <= hs_n;
            vs_q    <= vs_n;
            hblk_q  <= (hp_n >= H_VIS_X);
            vblk_q  <= (vp_n >= V_VIS_X);
            hsync_q <= h_win;
            vsync_q <= v_win;
            vbirq_q <= IRQ_EN && line_start && (vp_n == V_VIS_X);
            nmirq_q <= NMI_EN && line_start && ((vp_n & NMI_MASK) == '0);
            if (frame_start) frame_q <= ~frame_q;
         end
      end
   end

   assign VCLK_EN   = (div == 3'd7);
   assign VCLKx2_EN = (div[1:0] == 2'd3);
   assign VCLKx4_EN = div[0];
   assign HP        = hp_q;
   assign VP        = vp_q;
   assign HBLK      = hblk_q;
   assign VBLK      = vblk_q;
   assign HSYNC     = hsync_q;
   assign VSYNC     = vsync_q;
   assign VBIRQ     = vbirq_q;
   assign NMIRQ     = nmirq_q;
   assign FRAME     = frame_q;
endmodule
